// File: rtl/sd_spi_slave.sv
// sd_spi_slave: SPI mode-0 slave that exchanges fixed-length SD-style frames.
//
// A synchronized cs_n falling edge captures resp_data and starts a frame.
// Command bits are sampled on sclk rising edges. Response bits go out MSB
// first and shift on sclk falling edges.
// After FRAME_BITS bits, the received word is published on cmd_data with a
// one-cycle cmd_valid pulse. miso then idles high until cs_n rises.
// If cs_n rises before the frame completes, aborted pulses for one cycle and
// cmd_data is left untouched.
//
// Parameters
//   FRAME_BITS  : bits per command/response frame
//   SYNC_STAGES : synchronizer depth on sclk/mosi/cs_n (2 or more)
// Ports
//   clk, rst_n  : system clock, asynchronous active-low reset
//   sclk, mosi, cs_n : SPI pins from the master (asynchronous to clk)
//   miso        : serial response to the master
//   resp_data   : response word, captured at frame start
//   cmd_data    : last complete received frame
//   cmd_valid   : one-cycle pulse when cmd_data updates
//   frame_err   : SD framing status of cmd_data
//   aborted     : one-cycle pulse when cs_n rises mid-frame
//   busy        : high while a frame is being shifted
module sd_spi_slave #(
  parameter int FRAME_BITS  = 48,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs_n,
  output logic                  miso,
  input  logic [FRAME_BITS-1:0] resp_data,
  output logic [FRAME_BITS-1:0] cmd_data,
  output logic                  cmd_valid,
  output logic                  frame_err,
  output logic                  aborted,
  output logic                  busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FILL  = 2'd2
  } state_t;

  // An SD command frame is well formed when it starts with 0b01 and ends with a stop bit of 1.
  function automatic logic sd_frame_err(input logic [FRAME_BITS-1:0] frame);
    return !((frame[FRAME_BITS-1] == 1'b0) && (frame[FRAME_BITS-2] == 1'b1) && (frame[0] == 1'b1));
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_r, mosi_sync_r, cs_sync_r;
  logic                   sclk_prev_r, cs_prev_r;
  logic                   sclk_s, mosi_s, cs_s;
  logic                   sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;

  state_t                 state_r, state_s;
  logic [FRAME_BITS-1:0]  tx_r, tx_s, rx_r, rx_s, cmd_data_r, cmd_data_s;
  logic [CNT_W-1:0]       cnt_r, cnt_s;
  logic                   frame_err_r, frame_err_s;
  logic                   cmd_valid_r, cmd_valid_s;
  logic                   aborted_r, aborted_s;
  logic                   busy_r, busy_s;
  logic                   miso_r, miso_s;

  // Synchronize the SPI pins and keep the previous synchronized levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= '0;
      mosi_sync_r <= '1;
      cs_sync_r   <= '1;
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b1;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi};
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], cs_n};
      sclk_prev_r <= sclk_s;
      cs_prev_r   <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_r;
  assign sclk_fall_s = ~sclk_s & sclk_prev_r;
  assign cs_fall_s   = ~cs_s & cs_prev_r;
  assign cs_rise_s   = cs_s & ~cs_prev_r;

  // Next-state and datapath decisions for the frame FSM.
  always_comb begin
    state_s     = state_r;
    tx_s        = tx_r;
    rx_s        = rx_r;
    cnt_s       = cnt_r;
    cmd_data_s  = cmd_data_r;
    frame_err_s = frame_err_r;
    cmd_valid_s = 1'b0;
    aborted_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // Any sclk edge that coincides with the cs_n fall is deliberately ignored here.
        if (cs_fall_s) begin
          tx_s    = resp_data;
          rx_s    = '0;
          cnt_s   = '0;
          state_s = SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cs_rise_s) begin
          aborted_s = 1'b1;
          state_s   = IDLE;
        end else begin
          if (sclk_rise_s) begin
            rx_s  = {rx_r[FRAME_BITS-2:0], mosi_s};
            cnt_s = cnt_r + CNT_W'(1);
            // Publish directly from the final bit so the pulse comes one cycle sooner.
            if (cnt_r == LAST_BIT) begin
              cmd_data_s  = rx_s;
              frame_err_s = sd_frame_err(rx_s);
              cmd_valid_s = 1'b1;
              state_s     = FILL;
            end else begin
              state_s = SHIFT;
            end
          end else if (sclk_fall_s) begin
            tx_s = {tx_r[FRAME_BITS-2:0], 1'b1};
          end else begin
            state_s = SHIFT;
          end
        end
      end
      FILL: begin
        if (cs_rise_s) begin
          state_s = IDLE;
        end else begin
          state_s = FILL;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // miso and busy are registered from the next state so they align with the shift register.
    if (state_s == SHIFT) begin
      miso_s = tx_s[FRAME_BITS-1];
      busy_s = 1'b1;
    end else begin
      miso_s = 1'b1;
      busy_s = 1'b0;
    end
  end

  // Frame FSM state, shift registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      tx_r        <= '0;
      rx_r        <= '0;
      cnt_r       <= '0;
      cmd_data_r  <= '0;
      frame_err_r <= 1'b0;
      cmd_valid_r <= 1'b0;
      aborted_r   <= 1'b0;
      busy_r      <= 1'b0;
      miso_r      <= 1'b1;
    end else begin
      state_r     <= state_s;
      tx_r        <= tx_s;
      rx_r        <= rx_s;
      cnt_r       <= cnt_s;
      cmd_data_r  <= cmd_data_s;
      frame_err_r <= frame_err_s;
      cmd_valid_r <= cmd_valid_s;
      aborted_r   <= aborted_s;
      busy_r      <= busy_s;
      miso_r      <= miso_s;
    end
  end

  assign miso      = miso_r;
  assign cmd_data  = cmd_data_r;
  assign cmd_valid = cmd_valid_r;
  assign frame_err = frame_err_r;
  assign aborted   = aborted_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_sd_spi_slave.sv
// Testbench for sd_spi_slave.
// A bench-side SPI master drives the frames. The reference model is a queue
// of expected command words plus the last published word, pending-abort
// counters, and an independent SD framing rule. One compare process checks
// the DUT outputs against that model on every clk falling edge.
module tb_sd_spi_slave;

  localparam int FB   = 48;
  localparam int SS   = 2;
  localparam int HALF = 4;   // clk cycles per sclk half period (sclk = clk/8)

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          mosi = 1'b1;
  logic          cs_n = 1'b1;
  logic          miso;
  logic [FB-1:0] resp_data = '0;
  logic [FB-1:0] cmd_data;
  logic          cmd_valid, frame_err, aborted, busy;

  sd_spi_slave #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
    .resp_data(resp_data), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .frame_err(frame_err), .aborted(aborted), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  logic [FB-1:0] exp_q[$];
  logic [FB-1:0] exp_cmd_last = '0;
  logic          exp_err_last = 1'b0;
  int            exp_abort = 0;
  int            rise48_cyc = 0;
  logic [55:0]   rd;

  // SD rule: the frame must start with bits 0,1 and end with a 1.
  function automatic logic model_err(input logic [FB-1:0] f);
    return (f[47:46] != 2'b01) || (f[0] != 1'b1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after each rising edge, away from the DUT sampling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: checks the DUT outputs against the model on every falling edge.
  always @(negedge clk) begin : mon
    logic [FB-1:0] e;
    if (!rst_n) begin
      chk("rst_cmd_data", 64'(cmd_data), 64'd0);
      chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
      chk("rst_frame_err", 64'(frame_err), 64'd0);
      chk("rst_aborted", 64'(aborted), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_miso", 64'(miso), 64'd1);
    end else begin
      if (cmd_valid) begin
        chk("cmd_valid_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("cmd_data", 64'(cmd_data), 64'(e));
          chk("frame_err", 64'(frame_err), 64'(model_err(e)));
          chk("cmd_latency", 64'((cyc - rise48_cyc) <= SS + 2), 64'd1);
          exp_cmd_last = e;
          exp_err_last = model_err(e);
        end
      end else begin
        chk("cmd_data_hold", 64'(cmd_data), 64'(exp_cmd_last));
        chk("frame_err_hold", 64'(frame_err), 64'(exp_err_last));
      end
      if (aborted) begin
        chk("abort_expected", 64'(exp_abort > 0), 64'd1);
        if (exp_abort > 0) exp_abort--;
      end
    end
  end

  // The master sends the top nbits of tx, MSB first, and records the miso bits in rd.
  // coincide: cs_n falls together with an sclk rising edge, which the DUT must ignore.
  // rst_at >= 0: pulse reset just before that bit's rising edge.
  task automatic frame(input logic [55:0] tx, input int nbits, input logic [FB-1:0] resp,
                       input bit scramble, input bit coincide, input int rst_at);
    logic [63:0] r64;
    rd = '1;
    resp_data = resp;
    if (nbits >= FB && rst_at < 0) exp_q.push_back(tx[55:8]);
    if (coincide) begin
      cs_n = 1'b0;
      sclk = 1'b1;
      mosi = 1'b0;
      repeat (HALF) tick();
      sclk = 1'b0;
    end else begin
      cs_n = 1'b0;
    end
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[55-i];
      repeat (HALF) tick();
      if (i == 0) begin
        chk("busy_shift", 64'(busy), 64'd1);
        if (scramble) begin
          r64 = {$urandom(), $urandom()};
          resp_data = r64[47:0];
        end
      end
      rd[55-i] = miso;
      if (rst_at == i) begin
        rst_n = 1'b0;
        exp_q.delete();
        exp_cmd_last = '0;
        exp_err_last = 1'b0;
        exp_abort = 0;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b1;
        repeat (4) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_cmd", 64'(cmd_data), 64'd0);
        return;
      end
      sclk = 1'b1;
      if (i == FB - 1) rise48_cyc = cyc;
      repeat (HALF) tick();
      sclk = 1'b0;
    end
    repeat (HALF) tick();
    cs_n = 1'b1;
    if (nbits < FB) exp_abort++;
    repeat (12) tick();
    chk("cmd_pending", 64'(exp_q.size()), 64'd0);
    chk("abort_pending", 64'(exp_abort), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    chk("miso_idle", 64'(miso), 64'd1);
    if (!coincide) begin
      if (nbits >= FB) chk("miso_read", 64'(rd[55:8]), 64'(resp));
      else chk("miso_read_part", 64'(rd[55:8] >> (FB - nbits)), 64'(resp >> (FB - nbits)));
      if (nbits > FB) chk("miso_fill", 64'(rd[7:0]), 64'hFF);
    end
  endtask

  initial begin
    logic [63:0] a, b;
    logic [55:0] tx;
    int nb, sel;
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("reset_cmd_data", 64'(cmd_data), 64'd0);
    chk("reset_miso", 64'(miso), 64'd1);

    // Well-formed command with a known response.
    frame({48'h400000000095, 8'hFF}, 48, 48'h123456789ABC, 1'b0, 1'b0, -1);
    chk("basic_cmd", 64'(cmd_data), 64'h400000000095);
    chk("basic_err", 64'(frame_err), 64'd0);
    chk("basic_read", 64'(rd[55:8]), 64'h123456789ABC);

    // Bad start bits.
    frame({48'h000000000094, 8'hFF}, 48, 48'hA5A5A5A5A5A5, 1'b0, 1'b0, -1);
    chk("badfmt_cmd", 64'(cmd_data), 64'h000000000094);
    chk("badfmt_err", 64'(frame_err), 64'd1);

    // Abort after 20 bits, then a good frame.
    frame({48'h7FFFFFFFFFFF, 8'h00}, 20, 48'h0F0F0F0F0F0F, 1'b0, 1'b0, -1);
    chk("abort_keep_cmd", 64'(cmd_data), 64'h000000000094);
    chk("abort_keep_err", 64'(frame_err), 64'd1);
    frame({48'h4ABCDEF01235, 8'hFF}, 48, 48'hFEDCBA987654, 1'b0, 1'b0, -1);
    chk("after_abort_cmd", 64'(cmd_data), 64'h4ABCDEF01235);
    chk("after_abort_err", 64'(frame_err), 64'd0);

    // 56 clocks in one window.
    frame(56'h7123456789AB_00, 56, 48'h000000000000, 1'b0, 1'b0, -1);
    chk("long_cmd", 64'(cmd_data), 64'h7123456789AB);
    chk("long_fill", 64'(rd[7:0]), 64'hFF);

    // Reset at bit 30, then a clean frame.
    frame({48'h400000000001, 8'hFF}, 48, 48'h111111111111, 1'b0, 1'b0, 30);
    frame({48'h5100000000FF, 8'hFF}, 48, 48'h222222222222, 1'b0, 1'b0, -1);
    chk("post_reset_cmd", 64'(cmd_data), 64'h5100000000FF);
    chk("post_reset_err", 64'(frame_err), 64'd0);

    // sclk toggling while the slave is deselected.
    for (int i = 0; i < 20; i++) begin
      sclk = ~sclk;
      repeat (HALF) tick();
      chk("desel_miso", 64'(miso), 64'd1);
      chk("desel_busy", 64'(busy), 64'd0);
    end
    sclk = 1'b0;
    repeat (HALF) tick();

    // cs_n fall coincides with an sclk rising edge.
    frame({48'h4C0000000041, 8'hFF}, 48, 48'h333333333333, 1'b0, 1'b1, -1);
    chk("coincide_cmd", 64'(cmd_data), 64'h4C0000000041);

    // Randomized frames, with resp_data scrambled after the frame starts.
    for (int k = 0; k < 16; k++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      tx = a[55:0];
      if ($urandom_range(1) == 1) begin
        tx[55:54] = 2'b01;
        tx[8] = 1'b1;
      end
      sel = int'($urandom_range(3));
      if (sel == 0) nb = int'($urandom_range(47, 1));
      else if (sel == 3) nb = int'($urandom_range(56, 49));
      else nb = 48;
      frame(tx, nb, b[47:0], 1'b1, 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
